// File: rtl/apb_pkg.sv
// Shared definitions for the APB byte-memory slave: bus widths, FSM encoding
// and the saturating wait-counter helper.
package apb_pkg;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // Count up toward the limit and hold there so the counter can never wrap.
  function automatic logic [WAIT_CNT_W-1:0] wait_sat_inc(
    input logic [WAIT_CNT_W-1:0] cnt,
    input logic [WAIT_CNT_W-1:0] lim
  );
    logic [WAIT_CNT_W-1:0] res;
    if (cnt < lim) begin
      res = cnt + WAIT_CNT_W'(1);
    end else begin
      res = cnt;
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB slave-side bus bundle. PADDR carries the slave-local address only; the
// top address bit is decoded upstream into the per-slave select.
interface apb_slave_mem_if #(
  parameter int ADDR_W = apb_pkg::APB_ADDR_W - 1,
  parameter int DATA_W = apb_pkg::APB_DATA_W
);

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_mem_array.sv
// Byte storage for the APB slave: asynchronously cleared, written on the
// clock edge, read combinationally.
module apb_mem_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage update: full clear on reset, single-byte write otherwise.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a small byte memory, programmable wait states and an
// out-of-range error response.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            PCLK,
  input  logic            PRST,
  apb_slave_mem_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_V  = WAIT_CYCLES[WAIT_CNT_W-1:0];
  localparam logic [ADDR_W:0]       DEPTH_V = DEPTH[ADDR_W:0];

  apb_state_e        state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              write_q, write_d;

  logic              ready_s;
  logic              err_s;
  logic              mem_we_s;
  logic [DATA_W-1:0] mem_rdata_s;
  logic [DATA_W-1:0] prdata_s;

  // Transfer context and wait counter; all cleared asynchronously.
  always_ff @(posedge PCLK or negedge PRST) begin
    if (!PRST) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
    end
  end

  // Ready and error are pure functions of the registered transfer context.
  always_comb begin
    ready_s = 1'b0;
    err_s   = ({1'b0, addr_q} >= DEPTH_V);
    if (state_q == ST_ACCESS) begin
      ready_s = (wait_q == WAIT_V);
    end else begin
      ready_s = 1'b0;
    end
  end

  // Protocol FSM: latch on setup, count waits, complete or abort.
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    mem_we_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.PSEL && !bus.PENABLE) begin
          addr_d  = bus.PADDR;
          wdata_d = bus.PWDATA;
          write_d = bus.PWRITE;
          wait_d  = '0;
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!bus.PSEL) begin
          state_d = ST_IDLE;
        end else if (bus.PENABLE) begin
          if (ready_s) begin
            mem_we_s = write_q && !err_s;
            state_d  = ST_IDLE;
          end else begin
            wait_d = wait_sat_inc(wait_q, WAIT_V);
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read data is only presented for an in-range read that is completing.
  always_comb begin
    prdata_s = '0;
    if (ready_s && !write_q && !err_s) begin
      prdata_s = mem_rdata_s;
    end else begin
      prdata_s = '0;
    end
  end

  assign bus.PREADY  = ready_s;
  assign bus.PSLVERR = ready_s && err_s;
  assign bus.PRDATA  = prdata_s;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk_i   (PCLK),
    .rst_n_i (PRST),
    .we_i    (mem_we_s),
    .waddr_i (addr_q[IDX_W-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (addr_q[IDX_W-1:0]),
    .rdata_o (mem_rdata_s)
  );

endmodule

// File: tb/tb_apb_slave_mem.sv
// Directed bench for apb_slave_mem: one instance with two wait states, one
// with none, driven from a shared master model.
module tb_apb_slave_mem;

  logic       pclk;
  logic       prst;
  logic       dsel;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata;
  logic       ready, slverr;
  logic [7:0] rdata;

  int n_checks;
  int n_err;

  apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) if0 ();
  apb_slave_mem_if #(.ADDR_W(8), .DATA_W(8)) if1 ();

  assign if0.PSEL    = psel & ~dsel;
  assign if1.PSEL    = psel & dsel;
  assign if0.PENABLE = penable;
  assign if1.PENABLE = penable;
  assign if0.PWRITE  = pwrite;
  assign if1.PWRITE  = pwrite;
  assign if0.PADDR   = paddr;
  assign if1.PADDR   = paddr;
  assign if0.PWDATA  = pwdata;
  assign if1.PWDATA  = pwdata;

  assign ready  = dsel ? if1.PREADY  : if0.PREADY;
  assign slverr = dsel ? if1.PSLVERR : if0.PSLVERR;
  assign rdata  = dsel ? if1.PRDATA  : if0.PRDATA;

  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(2)) u_dut0 (
    .PCLK (pclk),
    .PRST (prst),
    .bus  (if0)
  );

  apb_slave_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u_dut1 (
    .PCLK (pclk),
    .PRST (prst),
    .bus  (if1)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  typedef struct {
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         exp_wait;
    logic       exp_err;
    logic [7:0] exp_rdata;
    logic       gap;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic go_idle();
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
  endtask

  // Full transfer starting at a falling edge; returns at the falling edge
  // right after the completing rising edge.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                      input int exp_wait, input logic exp_err, input logic [7:0] exp_rd,
                      input string nm);
    bit found;
    found   = 1'b0;
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    @(negedge pclk);
    penable = 1'b1;
    paddr   = addr ^ 8'h03;
    pwdata  = ~wd;
    for (int c = 0; c < 20; c++) begin
      if (ready === 1'b1) begin
        found = 1'b1;
        chk({nm, "_latency"}, 32'(c), 32'(exp_wait));
        chk({nm, "_pslverr"}, {31'd0, slverr}, {31'd0, exp_err});
        chk({nm, "_prdata"}, {24'd0, rdata}, {24'd0, exp_rd});
        break;
      end
      if (slverr !== 1'b0 || rdata !== 8'h00) begin
        n_checks++;
        n_err++;
        $display("FAIL %s_waitstate: pslverr=%0b prdata=0x%0h, expected 0 and 0x00", nm, slverr, rdata);
      end
      @(negedge pclk);
    end
    if (!found) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: PREADY=0 after 20 cycles, expected 1", nm);
      go_idle();
    end else begin
      @(negedge pclk);
      chk({nm, "_idle_ready"}, {31'd0, ready}, 32'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    dsel     = 1'b0;
    psel     = 1'b0;
    penable  = 1'b0;
    pwrite   = 1'b0;
    paddr    = 8'h00;
    pwdata   = 8'h00;
    prst     = 1'b0;

    vecs[0]  = '{1'b1, 8'h05, 8'hA5, 2, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b0, 8'h05, 8'h00, 2, 1'b0, 8'hA5, 1'b1};
    vecs[2]  = '{1'b1, 8'h40, 8'h11, 2, 1'b1, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 8'h40, 8'h00, 2, 1'b1, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 8'h00, 2, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 8'h05, 8'h00, 2, 1'b0, 8'hA5, 1'b1};
    vecs[6]  = '{1'b1, 8'h3F, 8'hC3, 2, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 8'h3F, 8'h00, 2, 1'b0, 8'hC3, 1'b1};
    vecs[8]  = '{1'b1, 8'hFF, 8'h77, 2, 1'b1, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 8'hFF, 8'h00, 2, 1'b1, 8'h00, 1'b1};
    vecs[10] = '{1'b0, 8'h06, 8'h00, 2, 1'b0, 8'h00, 1'b1};
    vecs[11] = '{1'b1, 8'h00, 8'h5E, 2, 1'b0, 8'h00, 1'b0};

    repeat (3) @(negedge pclk);
    chk("reset_pready",  {31'd0, if0.PREADY},  32'd0);
    chk("reset_pslverr", {31'd0, if0.PSLVERR}, 32'd0);
    chk("reset_prdata",  {24'd0, if0.PRDATA},  32'd0);
    chk("reset_pready1", {31'd0, if1.PREADY},  32'd0);
    prst = 1'b1;
    @(negedge pclk);

    // Enable without a preceding setup must be ignored.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 8'h06; pwdata = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("noset_pready", {31'd0, ready}, 32'd0);
    end
    go_idle();

    for (int i = 0; i < NV; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_wait,
           vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
      if (vecs[i].gap) go_idle();
    end
    xfer(1'b0, 8'h00, 8'h00, 2, 1'b0, 8'h5E, "rd_back_00");
    go_idle();

    // Abort: drop PSEL after one access cycle.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h07; pwdata = 8'h3C;
    @(negedge pclk);
    penable = 1'b1;
    chk("abort_acc1_pready", {31'd0, ready}, 32'd0);
    @(negedge pclk);
    chk("abort_acc2_pready", {31'd0, ready}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      chk("abort_after_pready", {31'd0, ready}, 32'd0);
    end
    xfer(1'b0, 8'h07, 8'h00, 2, 1'b0, 8'h00, "abort_rd07");
    go_idle();

    // Reset in the middle of a write to 0x09.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h09; pwdata = 8'h5A;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    @(negedge pclk);
    chk("rstmid_pre_pready", {31'd0, ready}, 32'd1);
    #2 prst = 1'b0;
    #1;
    chk("rstmid_pready",  {31'd0, ready},  32'd0);
    chk("rstmid_pslverr", {31'd0, slverr}, 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    prst = 1'b1;
    @(negedge pclk);
    xfer(1'b0, 8'h09, 8'h00, 2, 1'b0, 8'h00, "rstmid_rd09");
    xfer(1'b0, 8'h05, 8'h00, 2, 1'b0, 8'h00, "rstmid_rd05");
    xfer(1'b1, 8'h09, 8'h5A, 2, 1'b0, 8'h00, "rstmid_wr09");
    xfer(1'b0, 8'h09, 8'h00, 2, 1'b0, 8'h5A, "rstmid_rd09b");
    go_idle();

    // Zero-wait instance, back-to-back transfers.
    dsel = 1'b1;
    @(negedge pclk);
    xfer(1'b1, 8'h01, 8'hD1, 0, 1'b0, 8'h00, "w0_wr01");
    xfer(1'b1, 8'h02, 8'hE2, 0, 1'b0, 8'h00, "w0_wr02");
    xfer(1'b0, 8'h01, 8'h00, 0, 1'b0, 8'hD1, "w0_rd01");
    xfer(1'b0, 8'h02, 8'h00, 0, 1'b0, 8'hE2, "w0_rd02");
    xfer(1'b0, 8'h41, 8'h00, 0, 1'b1, 8'h00, "w0_rd41");
    go_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- ADDR_W, 8, slave-local address width (PADDR[7:0]; bit 8 is decoded upstream into SEL1/SEL2).
- DATA_W, 8, data width.
- DEPTH, 64, implemented byte locations (0..DEPTH-1).
- WAIT_CYCLES, 2, wait states inserted before PREADY (0..15).
REQ-002 SHALL have ports (name, direction, width, meaning):
- PCLK, in, 1, sole clock, rising edge.
- PRST, in, 1, reset, asynchronous, active-low.
- PSEL, in, 1, slave select (driven by master SEL1 or SEL2).
- PENABLE, in, 1, access phase.
- PWRITE, in, 1, 1 = write, 0 = read.
- PADDR, in, ADDR_W, byte address.
- PWDATA, in, DATA_W, write data.
- PRDATA, out, DATA_W, read data.
- PREADY, out, 1, transfer complete.
- PSLVERR, out, 1, transfer error, qualified by PREADY.

Function
REQ-003 SHALL implement FSM IDLE, ACCESS, encoded in the shared package.
REQ-004 In IDLE, a rising edge with PSEL=1 and PENABLE=0 (setup) SHALL latch PADDR, PWRITE and PWDATA, clear the wait counter to 0, and go to ACCESS.
REQ-005 In IDLE, PENABLE=1 without a preceding setup SHALL be ignored: no PREADY, no write, stay IDLE.
REQ-006 In ACCESS, PREADY SHALL be combinational: 1 iff wait counter == WAIT_CYCLES. With WAIT_CYCLES=0, PREADY is high in the first access cycle.
REQ-007 In ACCESS, each edge with PSEL=1, PENABLE=1 and PREADY=0 SHALL increment the 4-bit wait counter. The counter SHALL saturate at WAIT_CYCLES and never wrap.
REQ-008 In ACCESS, an edge with PSEL=1, PENABLE=1 and PREADY=1 completes the transfer:
- A write without error SHALL commit the latched data to mem[latched address].
- The FSM SHALL return to IDLE.
REQ-009 Back-to-back transfers SHALL work: the master's setup cycle immediately following completion is accepted from IDLE per REQ-004.
REQ-010 In ACCESS, PSEL=0 at any edge SHALL abort to IDLE with no write and no PREADY pulse.
REQ-011 Error: latched address >= DEPTH.
- PSLVERR SHALL be 1 exactly while PREADY=1 for that transfer.
- No write SHALL occur.
- PRDATA SHALL be 0.
REQ-012 A read without error SHALL drive PRDATA = mem[latched address] while PREADY=1. At all other times PRDATA=0.
REQ-013 PWDATA and PADDR changes during ACCESS SHALL have no effect; the latched values govern the transfer.
REQ-014 PREADY and PSLVERR SHALL be 0 in IDLE.

Reset
REQ-015 PRST low SHALL asynchronously force:
- state to IDLE.
- wait counter and latched address/data/write to 0.
- all memory bytes to 0x00.
- PREADY, PSLVERR and PRDATA to 0.
REQ-016 Reset asserted mid-ACCESS SHALL abandon the transfer with no memory write. The first setup after reset deassertion SHALL be accepted normally.

Structure
REQ-017 Package apb_pkg SHALL hold:
- state encoding (IDLE, ACCESS).
- APB address width 9 and data width 8.
- wait-counter width 4.
REQ-018 The storage array (async-reset byte array, sync write, async read) SHALL be a sub-module apb_mem_array. Protocol FSM, wait counter and error decode SHALL stay in apb_slave_mem.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Write, WAIT_CYCLES=2: setup addr 0x05 data 0xA5, then hold PENABLE. Required: PREADY high on the 3rd access cycle, PSLVERR=0, mem[5]=0xA5.
- Read back: setup addr 0x05 read. Required: PRDATA=0xA5 with PREADY, PSLVERR=0.
- Error: write addr 0x40 data 0x11 (DEPTH=64). Required: PREADY and PSLVERR high together, mem unchanged; a subsequent read of 0x40 returns PRDATA=0, PSLVERR=1.
- Abort: setup write addr 0x07 data 0x3C, drop PSEL after 1 access cycle. Required: no PREADY, mem[7] stays 0x00.
- Reset mid-access: assert PRST low during the wait of a write to 0x09. Required: PREADY=0 immediately, mem[9]=0x00; a new write to 0x09 after release succeeds.
- WAIT_CYCLES=0 back-to-back: writes to 0x01 then 0x02. Required: PREADY in the first access cycle of each, both bytes stored.
